// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: turns stopwatch buttons and set requests into single-cycle counter commands.
// Generates the count-enable tick and captures lap times.
// Ports:
//   clk_i, reset_i       system clock, synchronous active-high reset
//   start_btn_i          rising edge toggles run/pause
//   lap_btn_i            rising edge captures/releases a lap
//   clear_btn_i          rising edge zeroes the counter while stopped
//   set_req_i/set_ack_o  preset-load request and its one-cycle acknowledge
//   cnt_time_i           live counter value {hour, min, sec, ms}
//   cnt_en_o             one-cycle count-enable per tick
//   cnt_set_o/cnt_zero_o time-set strobe, qualified by zero (1) or preset (0) load
//   lap_time_o/lap_valid_o/disp_lap_o  frozen lap value, its valid flag, display select
//   state_o              IDLE=00 RUN=01 PAUSE=10 LAP=11
module stopwatch_ctrl #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_btn_i,
    input  logic        lap_btn_i,
    input  logic        clear_btn_i,
    input  logic        set_req_i,
    output logic        set_ack_o,
    input  logic [26:0] cnt_time_i,
    output logic        cnt_en_o,
    output logic        cnt_set_o,
    output logic        cnt_zero_o,
    output logic [26:0] lap_time_o,
    output logic        lap_valid_o,
    output logic        disp_lap_o,
    output logic [1:0]  state_o
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;

    state_t state, state_nxt;
    // Button vectors are ordered {clear, start, lap}.
    logic [2:0] btn_sync, btn_prev, btn_edge;
    logic [PW-1:0] presc, presc_nxt;
    logic armed, armed_nxt;
    logic running, clr_act, st_act, lap_act, set_go, tick;
    logic [26:0] lap_time_nxt;
    logic lap_valid_nxt;

    assign btn_edge = btn_sync & ~btn_prev;
    assign state_o = state;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            btn_sync <= '1;
            btn_prev <= '1;
            presc <= '0;
            armed <= 1'b0;
            cnt_en_o <= 1'b0;
            cnt_set_o <= 1'b0;
            cnt_zero_o <= 1'b0;
            set_ack_o <= 1'b0;
            lap_time_o <= '0;
            lap_valid_o <= 1'b0;
            disp_lap_o <= 1'b0;
        end else begin
            state <= state_nxt;
            btn_sync <= {clear_btn_i, start_btn_i, lap_btn_i};
            btn_prev <= btn_sync;
            presc <= presc_nxt;
            armed <= armed_nxt;
            cnt_en_o <= tick;
            cnt_set_o <= clr_act | set_go;
            cnt_zero_o <= clr_act;
            set_ack_o <= set_go;
            lap_time_o <= lap_time_nxt;
            lap_valid_o <= lap_valid_nxt;
            disp_lap_o <= state_nxt == LAP;
        end
    end

    always_comb begin
        running = state == RUN || state == LAP;
        // Clear is only meaningful when stopped; start is valid everywhere; lap only while running.
        clr_act = btn_edge[2] & ~running;
        st_act = btn_edge[1] & ~clr_act;
        lap_act = btn_edge[0] & ~btn_edge[1] & running;
        // Sets are only taken when stopped, so cnt_set_o and cnt_en_o can never coincide.
        set_go = set_req_i & armed & ~running & ~clr_act;
        tick = running & (presc == LAST);
        presc_nxt = (clr_act | tick) ? '0 : running ? presc + 1'b1 : presc;
        armed_nxt = set_go ? 1'b0 : armed | ~set_req_i;
        lap_time_nxt = clr_act ? '0 : (lap_act && state == RUN) ? cnt_time_i : lap_time_o;
        lap_valid_nxt = ~clr_act & (lap_valid_o | (lap_act & (state == RUN)));
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = st_act ? RUN : IDLE;
            RUN:   state_nxt = st_act ? PAUSE : lap_act ? LAP : RUN;
            LAP:   state_nxt = st_act ? PAUSE : lap_act ? RUN : LAP;
            PAUSE: state_nxt = clr_act ? IDLE : st_act ? RUN : PAUSE;
        endcase
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: randomized and directed bench for stopwatch_ctrl with a table-driven
// reference model feeding a per-cycle expected-output queue.
module tb_stopwatch_ctrl;
    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_btn = 1'b0, lap_btn = 1'b0, clear_btn = 1'b0, set_req = 1'b0;
    logic [26:0] cnt_time = '0;
    logic set_ack, cnt_en, cnt_set, cnt_zero, lap_valid, disp_lap;
    logic [26:0] lap_time;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(.CLK_HZ(10000), .TICK_HZ(1000)) dut (
        .clk_i(clk), .reset_i(rst),
        .start_btn_i(start_btn), .lap_btn_i(lap_btn), .clear_btn_i(clear_btn),
        .set_req_i(set_req), .set_ack_o(set_ack),
        .cnt_time_i(cnt_time), .cnt_en_o(cnt_en), .cnt_set_o(cnt_set), .cnt_zero_o(cnt_zero),
        .lap_time_o(lap_time), .lap_valid_o(lap_valid), .disp_lap_o(disp_lap), .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, got, req, $time);
        end
    endtask

    function automatic logic [34:0] outs();
        return {state, cnt_en, cnt_set, cnt_zero, set_ack, lap_time, lap_valid, disp_lap};
    endfunction

    // Reference model. States 0 IDLE, 1 RUN, 2 PAUSE, 3 LAP; buttons 0 clear, 1 start, 2 lap
    // in priority order. Table entry is the next state, or -1 where the button is not valid.
    int nxt_tbl [4][3] = '{'{0, 1, -1}, '{-1, 2, 3}, '{0, 1, -1}, '{-1, 2, 1}};
    int m_state, run_cnt, act, ns;
    bit m_armed, m_lv, m_en, m_go, m_run;
    bit [2:0] hist1, hist2;
    logic [26:0] m_lap;
    logic [34:0] q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0; run_cnt = 0; m_armed = 0; m_lv = 0; m_lap = '0;
            hist1 = '1; hist2 = '1;
            q.push_back('0);
        end else begin
            act = -1;
            for (int b = 0; b < 3; b++)
                if (act < 0 && hist1[b] && !hist2[b] && nxt_tbl[m_state][b] >= 0) act = b;
            m_run = m_state == 1 || m_state == 3;
            m_go = set_req && m_armed && !m_run && act != 0;
            m_en = 0;
            if (m_run) begin
                run_cnt++;
                m_en = run_cnt % DIV == 0;
            end
            if (act == 0) begin
                run_cnt = 0; m_lap = '0; m_lv = 0;
            end
            if (act == 2 && m_state == 1) begin
                m_lap = cnt_time; m_lv = 1;
            end
            m_armed = m_go ? 1'b0 : (m_armed || !set_req);
            ns = act < 0 ? m_state : nxt_tbl[m_state][act];
            m_state = ns;
            q.push_back({2'(m_state), m_en, m_go || act == 0, act == 0, m_go, m_lap, m_lv, ns == 3});
            hist2 = hist1;
            hist1 = {lap_btn, start_btn, clear_btn};
        end
    end

    always @(negedge clk) begin
        logic [34:0] exp_v;
        if (q.size() > 0) begin
            exp_v = q.pop_front();
            chk("outputs", 64'(outs()), 64'(exp_v));
        end
    end

    task automatic press(input bit c, input bit s, input bit l);
        clear_btn = c; start_btn = s; lap_btn = l;
        @(negedge clk);
        clear_btn = 0; start_btn = 0; lap_btn = 0;
    endtask

    task automatic wait_state(input logic [1:0] s, input string nm);
        int n = 0;
        while (state !== s && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(state), 64'(s));
    endtask

    initial begin
        int cnt, last, first, acks, sets;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(outs()), 64'd0);
        rst = 0;
        repeat (2) @(negedge clk);

        press(0, 1, 0);
        wait_state(2'b01, "enter_run");
        cnt = 0; last = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (cnt_en) begin
                cnt++;
                if (last >= 0) chk("en_spacing", 64'(k - last), 64'(DIV));
                else chk("en_first", 64'(k), 64'(DIV));
                last = k;
            end
        end
        chk("en_count", 64'(cnt), 64'd10);

        press(0, 1, 0);
        wait_state(2'b10, "pause1");
        press(1, 0, 0);
        wait_state(2'b00, "clear_to_idle");
        press(0, 1, 0);
        wait_state(2'b01, "run2");
        repeat (23) @(negedge clk);
        press(0, 1, 0);
        wait_state(2'b10, "pause2");
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            cnt += int'(cnt_en);
        end
        chk("en_while_paused", 64'(cnt), 64'd0);
        press(0, 1, 0);
        wait_state(2'b01, "resume");
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (cnt_en && first < 0) first = k;
        end
        chk("resume_first_tick", 64'(first), 64'(DIV - 25 % DIV));

        cnt_time = 27'h0001234;
        press(0, 0, 1);
        wait_state(2'b11, "enter_lap");
        chk("lap_time", 64'(lap_time), 64'h1234);
        chk("lap_valid", 64'(lap_valid), 64'd1);
        chk("disp_lap_on", 64'(disp_lap), 64'd1);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += int'(cnt_en);
        end
        chk("lap_en_count", 64'(cnt), 64'd2);
        cnt_time = 27'h5abcdef;
        press(0, 0, 1);
        wait_state(2'b01, "lap_release");
        chk("lap_time_kept", 64'(lap_time), 64'h1234);
        chk("disp_lap_off", 64'(disp_lap), 64'd0);

        press(0, 1, 0);
        wait_state(2'b10, "pause3");
        set_req = 1;
        acks = 0; sets = 0;
        repeat (5) begin
            @(negedge clk);
            acks += int'(set_ack);
            sets += int'(cnt_set & ~cnt_zero);
        end
        set_req = 0;
        chk("set_ack_count", 64'(acks), 64'd1);
        chk("set_load_count", 64'(sets), 64'd1);
        @(negedge clk);
        press(0, 1, 0);
        wait_state(2'b01, "run_set_pending");
        set_req = 1;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            acks += int'(set_ack);
        end
        chk("no_ack_in_run", 64'(acks), 64'd0);
        press(0, 1, 0);
        wait_state(2'b10, "pause_set_pending");
        chk("ack_not_early", 64'(set_ack), 64'd0);
        @(negedge clk);
        chk("ack_first_pause", 64'({set_ack, cnt_set, cnt_zero}), 64'b110);
        set_req = 0;

        press(1, 1, 0);
        sets = 0;
        repeat (4) begin
            @(negedge clk);
            sets += int'(cnt_set & cnt_zero);
        end
        chk("clear_start_state", 64'(state), 64'd0);
        chk("clear_zero_load", 64'(sets), 64'd1);
        chk("clear_lap_valid", 64'(lap_valid), 64'd0);
        press(0, 1, 0);
        wait_state(2'b01, "run_before_clear");
        press(1, 0, 0);
        sets = 0;
        repeat (4) begin
            @(negedge clk);
            sets += int'(cnt_set);
        end
        chk("clear_ignored_state", 64'(state), 64'd1);
        chk("clear_ignored_set", 64'(sets), 64'd0);
        press(0, 0, 1);
        wait_state(2'b11, "lap_before_reset");
        set_req = 1;
        rst = 1;
        @(negedge clk);
        chk("reset_in_lap", 64'(outs()), 64'd0);
        set_req = 0;
        rst = 0;

        for (int i = 0; i < 4000; i++) begin
            start_btn = $urandom_range(0, 15) == 0;
            clear_btn = $urandom_range(0, 23) == 0;
            lap_btn = $urandom_range(0, 11) == 0;
            if ($urandom_range(0, 5) == 0) set_req = ~set_req;
            cnt_time = 27'($urandom);
            rst = $urandom_range(0, 999) == 0;
            @(negedge clk);
        end
        rst = 0; start_btn = 0; clear_btn = 0; lap_btn = 0; set_req = 0;
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch counter datapath (hour/min/sec/ms counter with time-set load and a count enable). Turns raw start/lap/clear buttons and a set-time request into single-cycle counter commands. Generates the 1 ms count-enable from the system clock and captures lap times for the display. Sits between the board I/O and the counter; its outputs drive the counter's count-enable and time-set inputs directly.

## Interface

- `CLK_HZ`, default 100_000_000: system clock frequency.
- `TICK_HZ`, default 1000: count-enable rate. `DIV = CLK_HZ/TICK_HZ`, integer ≥ 2. The prescaler is `$clog2(DIV)` bits wide.
- `clk_i` in 1: system clock. Single clock domain.
- `reset_i` in 1: synchronous, active-high reset.
- `start_btn_i` in 1: level input. A rising edge toggles run/pause.
- `lap_btn_i` in 1: level input. A rising edge captures or releases a lap.
- `clear_btn_i` in 1: level input. A rising edge zeroes the counter while paused.
- `set_req_i` in 1: level request to load preset time into the counter.
- `set_ack_o` out 1: one-cycle acknowledge of `set_req_i`.
- `cnt_time_i` in 27: live counter value `{hour[4:0], min[5:0], sec[5:0], ms[9:0]}`.
- `cnt_en_o` out 1: counter count-enable. One-cycle pulse per tick.
- `cnt_set_o` out 1: counter time-set strobe. One-cycle pulse.
- `cnt_zero_o` out 1: qualifies `cnt_set_o`. 1 = load zeros; 0 = load preset values.
- `lap_time_o` out 27: frozen lap value.
- `lap_valid_o` out 1: `lap_time_o` holds a captured value.
- `disp_lap_o` out 1: 1 = display shows `lap_time_o`; 0 = display shows live time.
- `state_o` out 2: encoding IDLE=00, RUN=01, PAUSE=10, LAP=11.

## Operation

- **Button inputs.**
  - Each button input passes through one sync register, then a prev register.
  - Edge = sync & ~prev.
  - Sync and prev registers reset to 1, so a button held through reset release produces no edge.
- **Edge priority within one cycle:** clear > start > lap. Only the highest-priority edge valid in the current state acts; the others are discarded.
- **State machine:**
  - IDLE: start → RUN. Clear → `cnt_set_o`=1 and `cnt_zero_o`=1 for one cycle; stay in IDLE. Lap is ignored.
  - RUN: start → PAUSE. Lap → LAP, with `lap_time_o` ← `cnt_time_i`, `lap_valid_o`=1, `disp_lap_o`=1. Clear is ignored.
  - LAP (counter keeps running, display frozen): lap → RUN with `disp_lap_o`=0; `lap_time_o` and `lap_valid_o` are retained. Start → PAUSE with `disp_lap_o`=0. Clear is ignored.
  - PAUSE: start → RUN. Clear → IDLE, with a zero-load pulse (`cnt_set_o`=1, `cnt_zero_o`=1), `lap_valid_o`=0, `lap_time_o`=0, and prescaler=0. Lap is ignored.
- **Prescaler.**
  - Counts 0..DIV-1, and only in RUN or LAP.
  - At DIV-1: `cnt_en_o`=1 for that cycle, then the prescaler wraps to 0.
  - In PAUSE/IDLE it holds its value, so the sub-tick fraction is preserved across a pause.
  - It is zeroed by reset and by clear.
- **Set handshake.**
  - Accepted only in IDLE or PAUSE, when `set_req_i`=1 and the request is armed.
  - On acceptance: `cnt_set_o`=1, `cnt_zero_o`=0, and `set_ack_o`=1, all for exactly one cycle; the state is unchanged.
  - The request is re-armed only after `set_req_i` has been seen low for ≥1 cycle. One ack is given per request.
  - In RUN/LAP the request stays pending; it is accepted on the first cycle after entering PAUSE.
- **Same-cycle conflicts.**
  - A clear edge and an accepted set in the same cycle: clear wins, and the set stays pending for the next cycle.
  - `cnt_set_o` never asserts in the same cycle as `cnt_en_o`.

## Timing

- **Reset values:** state IDLE, prescaler 0, and every output 0: `cnt_en_o`, `cnt_set_o`, `cnt_zero_o`, `set_ack_o`, `lap_time_o`, `lap_valid_o`, `disp_lap_o`, `state_o`.
- **Button latency.** A button that rises before edge N is synced at edge N. The state change and any registered outputs appear after edge N+1 (2-cycle latency).
- **Set latency.**
  - `set_req_i` is sampled directly, not synchronised; the requester is in the same domain.
  - A request high before edge N gives `set_ack_o`/`cnt_set_o` high from edge N to N+1.
- **Lap capture.** `lap_time_o` is the value of `cnt_time_i` sampled at the same edge that enters LAP.
- **Tick rate.** In continuous RUN, `cnt_en_o` pulses are exactly DIV cycles apart. The first pulse after IDLE→RUN comes DIV cycles after entering RUN.
- **Outputs.** All outputs are registered; there are no combinational input-to-output paths.
- **Mid-operation reset.** Asserting `reset_i` in any state returns the block to reset values on the next edge. A pending set is dropped, and no `cnt_set_o` is issued.

## Test plan

All scenarios use `CLK_HZ`=10000 and `TICK_HZ`=1000, so DIV=10.

- **Reset then run.**
  - Stimulus: reset, then pulse start; run 100 cycles.
  - Required: `state_o`=01 two cycles after the start edge; exactly 10 `cnt_en_o` pulses, spaced 10 cycles apart.
- **Pause preserves fraction.**
  - Stimulus: start, wait 25 cycles, pause for 50 cycles, then start again.
  - Required: no `cnt_en_o` while paused; the next pulse arrives 5 run-cycles after resume.
- **Lap capture.**
  - Stimulus: in RUN with `cnt_time_i`=27'h0001234, press lap.
  - Required: `lap_time_o`=27'h0001234, `lap_valid_o`=1, `disp_lap_o`=1, `state_o`=11, and `cnt_en_o` keeps pulsing.
  - Then press lap again: `disp_lap_o`=0, `state_o`=01, and `lap_time_o` is unchanged.
- **Set handshake.**
  - In PAUSE, hold `set_req_i` high for 5 cycles. Required: exactly one `set_ack_o`/`cnt_set_o` pulse with `cnt_zero_o`=0.
  - Assert `set_req_i` in RUN, then pause. Required: the ack arrives on the first PAUSE cycle.
- **Clear, simultaneity and reset.**
  - Press clear and start in the same cycle in PAUSE. Required: → IDLE, one `cnt_set_o` with `cnt_zero_o`=1, `lap_valid_o`=0.
  - Press clear in RUN. Required: ignored.
  - Assert `reset_i` in LAP. Required: all outputs 0 on the next edge.
